// File: rtl/output_port_credit_tracker_pkg.sv
// rtl/output_port_credit_tracker_pkg.sv - shared router flit-format and credit constants
package output_port_credit_tracker_pkg;
  localparam int V      = 4;
  localparam int P      = 5;
  localparam int FPAY   = 32;
  localparam int B      = 4;
  localparam int FW     = 2 + V + FPAY;
  localparam int HDR_BIT  = FW - 1;
  localparam int TAIL_BIT = FW - 2;
  localparam int VC_LSB   = FPAY;
  localparam int VC_MSB   = FPAY + V - 1;
  localparam int CRDW     = $clog2(B + 1);
endpackage

// File: rtl/output_port_credit_tracker_port_credit_vc_tracker.sv
// rtl/output_port_credit_tracker_port_credit_vc_tracker.sv - per-port credit counters, VC ownership and error flag
module port_credit_vc_tracker #(
  parameter int V    = output_port_credit_tracker_pkg::V,
  parameter int Fpay = output_port_credit_tracker_pkg::FPAY,
  parameter int B    = output_port_credit_tracker_pkg::B
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2+V+Fpay-1:0]   i_flit,
  input  logic                  i_we,
  input  logic [V-1:0]          i_credit,
  output logic [V-1:0]          o_credit_avail,
  output logic [V-1:0]          o_vc_free,
  output logic                  o_err
);
  localparam int FW   = 2 + V + Fpay;
  localparam int CRDW = $clog2(B + 1);
  localparam logic [CRDW-1:0] CNT_MAX = CRDW'(B);
  localparam logic [CRDW-1:0] CNT_ONE = CRDW'(1);
  localparam logic [V-1:0]    VC_ONE  = V'(1);

  logic [CRDW-1:0] r_cnt [V];
  logic [CRDW-1:0] w_cnt_nxt [V];
  logic [V-1:0]    r_free;
  logic [V-1:0]    w_free_nxt;
  logic            r_err;
  logic            w_err_evt;

  logic [V-1:0] w_vc;
  logic         w_hdr;
  logic         w_tail;
  logic         w_onehot;
  logic [V-1:0] w_send;

  assign w_vc     = i_flit[Fpay+V-1:Fpay];
  assign w_hdr    = i_flit[FW-1];
  assign w_tail   = i_flit[FW-2];
  assign w_onehot = (w_vc != '0) && ((w_vc & (w_vc - VC_ONE)) == '0);
  // A malformed VC field never touches a counter or VC state.
  assign w_send   = (i_we && w_onehot) ? w_vc : '0;

  // Next-state for counters, VC ownership and any protocol violation this cycle.
  always_comb begin
    w_err_evt  = i_we && !w_onehot;
    w_free_nxt = r_free;
    for (int v = 0; v < V; v++) begin
      w_cnt_nxt[v] = r_cnt[v];
      if (w_send[v] && !i_credit[v]) begin
        if (r_cnt[v] == '0) w_err_evt = 1'b1;
        else                w_cnt_nxt[v] = r_cnt[v] - CNT_ONE;
      end else if (!w_send[v] && i_credit[v]) begin
        if (r_cnt[v] == CNT_MAX) w_err_evt = 1'b1;
        else                     w_cnt_nxt[v] = r_cnt[v] + CNT_ONE;
      end
      if (w_send[v]) begin
        if (w_hdr && !w_tail) begin
          if (!r_free[v]) w_err_evt = 1'b1;
          w_free_nxt[v] = 1'b0;
        end else if (w_tail && !w_hdr) begin
          w_free_nxt[v] = 1'b1;
        end
      end
    end
  end

  // State registers; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < V; v++) r_cnt[v] <= CNT_MAX;
      r_free <= '1;
      r_err  <= 1'b0;
    end else begin
      for (int v = 0; v < V; v++) r_cnt[v] <= w_cnt_nxt[v];
      r_free <= w_free_nxt;
      r_err  <= r_err | w_err_evt;
    end
  end

  // Allocator-facing status decoded from registered state only.
  always_comb begin
    for (int v = 0; v < V; v++) o_credit_avail[v] = (r_cnt[v] != '0);
  end

  assign o_vc_free = r_free;
  assign o_err     = r_err;
endmodule

// File: rtl/output_port_credit_tracker.sv
// rtl/output_port_credit_tracker.sv - output link register plus per-port credit/VC trackers
module output_port_credit_tracker
  import output_port_credit_tracker_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [P*FW-1:0] flit_in_all,
  input  logic [P-1:0]    flit_in_we_all,
  input  logic [P*V-1:0]  credit_in_all,
  output logic [P*FW-1:0] flit_out_all,
  output logic [P-1:0]    flit_out_we_all,
  output logic [P*V-1:0]  credit_avail_all,
  output logic [P*V-1:0]  vc_free_all,
  output logic [P-1:0]    credit_err_all
);
  logic [P*FW-1:0] r_flit_out;
  logic [P-1:0]    r_flit_we;

  // Link pipeline: one unconditional register stage, no backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flit_out <= '0;
      r_flit_we  <= '0;
    end else begin
      r_flit_out <= flit_in_all;
      r_flit_we  <= flit_in_we_all;
    end
  end

  assign flit_out_all    = r_flit_out;
  assign flit_out_we_all = r_flit_we;

  for (genvar p = 0; p < P; p++) begin : g_port
    port_credit_vc_tracker #(
      .V    (V),
      .Fpay (FPAY),
      .B    (B)
    ) u_trk (
      .clk            (clk),
      .reset          (reset),
      .i_flit         (flit_in_all[p*FW +: FW]),
      .i_we           (flit_in_we_all[p]),
      .i_credit       (credit_in_all[p*V +: V]),
      .o_credit_avail (credit_avail_all[p*V +: V]),
      .o_vc_free      (vc_free_all[p*V +: V]),
      .o_err          (credit_err_all[p])
    );
  end
endmodule

// File: tb/tb_output_port_credit_tracker.sv
// tb/tb_output_port_credit_tracker.sv - directed self-checking bench for the credit tracker
module tb_output_port_credit_tracker;
  import output_port_credit_tracker_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [P*FW-1:0] flit_in_all;
  logic [P-1:0]    flit_in_we_all;
  logic [P*V-1:0]  credit_in_all;
  logic [P*FW-1:0] flit_out_all;
  logic [P-1:0]    flit_out_we_all;
  logic [P*V-1:0]  credit_avail_all;
  logic [P*V-1:0]  vc_free_all;
  logic [P-1:0]    credit_err_all;

  int checks   = 0;
  int failures = 0;

  output_port_credit_tracker dut (
    .clk              (clk),
    .reset            (reset),
    .flit_in_all      (flit_in_all),
    .flit_in_we_all   (flit_in_we_all),
    .credit_in_all    (credit_in_all),
    .flit_out_all     (flit_out_all),
    .flit_out_we_all  (flit_out_we_all),
    .credit_avail_all (credit_avail_all),
    .vc_free_all      (vc_free_all),
    .credit_err_all   (credit_err_all)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    flit_in_all    = '0;
    flit_in_we_all = '0;
    credit_in_all  = '0;
  endtask

  task automatic put_flit(input int p, input logic hdr, input logic tail,
                          input logic [V-1:0] vc, input logic [FPAY-1:0] pay);
    flit_in_all[p*FW +: FW] = {hdr, tail, vc, pay};
    flit_in_we_all[p]       = 1'b1;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (flit_out_we_all !== 5'h00) begin
      failures++; $display("FAIL reset_we got=%h exp=00", flit_out_we_all);
    end
    checks++;
    if (flit_out_all !== '0) begin
      failures++; $display("FAIL reset_flit_out got=%h exp=0", flit_out_all);
    end
    checks++;
    if (credit_avail_all !== 20'hFFFFF) begin
      failures++; $display("FAIL reset_avail got=%h exp=fffff", credit_avail_all);
    end
    checks++;
    if (vc_free_all !== 20'hFFFFF) begin
      failures++; $display("FAIL reset_vc_free got=%h exp=fffff", vc_free_all);
    end
    checks++;
    if (credit_err_all !== 5'h00) begin
      failures++; $display("FAIL reset_err got=%h exp=00", credit_err_all);
    end
  endtask

  task automatic test_packet_stream();
    logic [FW-1:0] exp_flit;
    logic [3:0]    exp_avail;
    logic          exp_free;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clr_in();
      put_flit(1, (i == 0), (i == 3), 4'b0100, 32'hA000_0000 + 32'(i));
      exp_flit = {(i == 0), (i == 3), 4'b0100, 32'hA000_0000 + 32'(i)};
      tick();
      exp_avail = (i == 3) ? 4'b1011 : 4'b1111;
      exp_free  = (i == 3);
      checks++;
      if (flit_out_all[FW +: FW] !== exp_flit || flit_out_we_all !== 5'b00010) begin
        failures++;
        $display("FAIL stream_link_%0d got=%h/%b exp=%h/00010", i, flit_out_all[FW +: FW], flit_out_we_all, exp_flit);
      end
      checks++;
      if (credit_avail_all[7:4] !== exp_avail) begin
        failures++; $display("FAIL stream_avail_%0d got=%b exp=%b", i, credit_avail_all[7:4], exp_avail);
      end
      checks++;
      if (vc_free_all[6] !== exp_free) begin
        failures++; $display("FAIL stream_vc_free_%0d got=%b exp=%b", i, vc_free_all[6], exp_free);
      end
    end
    clr_in();
    tick();
    checks++;
    if (flit_out_we_all !== 5'h00 || credit_err_all !== 5'h00) begin
      failures++; $display("FAIL stream_idle got=%b/%b exp=00000/00000", flit_out_we_all, credit_err_all);
    end
    for (int i = 0; i < 4; i++) begin
      clr_in();
      credit_in_all[1*V+2] = 1'b1;
      tick();
    end
    clr_in();
    checks++;
    if (credit_avail_all[6] !== 1'b1 || credit_err_all !== 5'h00) begin
      failures++; $display("FAIL stream_refill got=%b/%b exp=1/00000", credit_avail_all[6], credit_err_all);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clr_in();
      put_flit(0, 1'b1, 1'b1, 4'b0001, 32'(i));
      tick();
    end
    clr_in();
    put_flit(0, 1'b1, 1'b1, 4'b0001, 32'h55);
    credit_in_all[0] = 1'b1;
    tick();
    clr_in();
    checks++;
    if (credit_avail_all[0] !== 1'b1 || credit_err_all[0] !== 1'b0) begin
      failures++; $display("FAIL same_cycle_hold got=%b/%b exp=1/0", credit_avail_all[0], credit_err_all[0]);
    end
    put_flit(0, 1'b1, 1'b1, 4'b0001, 32'h66);
    tick();
    clr_in();
    checks++;
    if (credit_avail_all[0] !== 1'b0 || credit_err_all[0] !== 1'b0) begin
      failures++; $display("FAIL same_cycle_last got=%b/%b exp=0/0", credit_avail_all[0], credit_err_all[0]);
    end
  endtask

  task automatic test_boundary_errors();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clr_in();
      put_flit(3, 1'b1, 1'b1, 4'b0010, 32'(i));
      tick();
    end
    clr_in();
    checks++;
    if (credit_avail_all[13] !== 1'b0 || credit_err_all[3] !== 1'b0) begin
      failures++; $display("FAIL drain_to_zero got=%b/%b exp=0/0", credit_avail_all[13], credit_err_all[3]);
    end
    put_flit(3, 1'b1, 1'b1, 4'b0010, 32'h77);
    tick();
    clr_in();
    checks++;
    if (credit_err_all[3] !== 1'b1 || credit_avail_all[13] !== 1'b0) begin
      failures++; $display("FAIL underflow got=%b/%b exp=1/0", credit_err_all[3], credit_avail_all[13]);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (credit_err_all[3] !== 1'b1) begin
      failures++; $display("FAIL underflow_sticky got=%b exp=1", credit_err_all[3]);
    end
    credit_in_all[3*V+1] = 1'b1;
    tick();
    clr_in();
    put_flit(3, 1'b1, 1'b1, 4'b0010, 32'h88);
    tick();
    clr_in();
    checks++;
    if (credit_avail_all[13] !== 1'b0) begin
      failures++; $display("FAIL underflow_held_zero got=%b exp=0", credit_avail_all[13]);
    end
    credit_in_all[4*V+2] = 1'b1;
    tick();
    clr_in();
    checks++;
    if (credit_err_all[4] !== 1'b1 || credit_avail_all[18] !== 1'b1) begin
      failures++; $display("FAIL overflow got=%b/%b exp=1/1", credit_err_all[4], credit_avail_all[18]);
    end
    for (int i = 0; i < 4; i++) begin
      clr_in();
      put_flit(4, 1'b1, 1'b1, 4'b0100, 32'(i));
      tick();
    end
    clr_in();
    checks++;
    if (credit_avail_all[18] !== 1'b0) begin
      failures++; $display("FAIL overflow_held_max got=%b exp=0", credit_avail_all[18]);
    end
  endtask

  task automatic test_malformed_and_single();
    do_reset();
    put_flit(2, 1'b1, 1'b0, 4'b0110, 32'h99);
    put_flit(1, 1'b1, 1'b0, 4'b0000, 32'h9A);
    tick();
    clr_in();
    checks++;
    if (credit_err_all !== 5'b00110) begin
      failures++; $display("FAIL bad_onehot_err got=%b exp=00110", credit_err_all);
    end
    checks++;
    if (vc_free_all !== 20'hFFFFF || credit_avail_all !== 20'hFFFFF) begin
      failures++; $display("FAIL bad_onehot_state got=%h/%h exp=fffff/fffff", vc_free_all, credit_avail_all);
    end
    for (int i = 0; i < 3; i++) begin
      clr_in();
      put_flit(2, 1'b1, 1'b1, 4'b0100, 32'(i));
      tick();
    end
    clr_in();
    checks++;
    if (credit_avail_all[10] !== 1'b1) begin
      failures++; $display("FAIL bad_onehot_cnt got=%b exp=1", credit_avail_all[10]);
    end
    put_flit(4, 1'b1, 1'b1, 4'b0001, 32'hBEEF);
    tick();
    clr_in();
    checks++;
    if (vc_free_all[16] !== 1'b1 || credit_avail_all[16] !== 1'b1 || credit_err_all[4] !== 1'b0) begin
      failures++;
      $display("FAIL single_flit got=%b/%b/%b exp=1/1/0", vc_free_all[16], credit_avail_all[16], credit_err_all[4]);
    end
    for (int i = 0; i < 3; i++) begin
      clr_in();
      put_flit(4, 1'b1, 1'b1, 4'b0001, 32'(i));
      tick();
    end
    clr_in();
    checks++;
    if (credit_avail_all[16] !== 1'b0) begin
      failures++; $display("FAIL single_flit_cnt got=%b exp=0", credit_avail_all[16]);
    end
  endtask

  task automatic test_all_ports();
    logic [P*FW-1:0] exp_out;
    do_reset();
    exp_out = '0;
    for (int p = 0; p < P; p++) begin
      put_flit(p, 1'b1, 1'b0, 4'b0001, 32'hC000_0000 + 32'(p));
      exp_out[p*FW +: FW] = {1'b1, 1'b0, 4'b0001, 32'hC000_0000 + 32'(p)};
      credit_in_all[p*V+3] = 1'b1;
    end
    tick();
    clr_in();
    checks++;
    if (flit_out_all !== exp_out || flit_out_we_all !== 5'h1F) begin
      failures++; $display("FAIL all_ports_link got=%h/%b exp=%h/11111", flit_out_all, flit_out_we_all, exp_out);
    end
    checks++;
    if (vc_free_all !== 20'hEEEEE || credit_err_all !== 5'h1F) begin
      failures++; $display("FAIL all_ports_state got=%h/%b exp=eeeee/11111", vc_free_all, credit_err_all);
    end
    for (int i = 0; i < 3; i++) begin
      clr_in();
      for (int p = 0; p < P; p++) put_flit(p, 1'b0, 1'b0, 4'b0001, 32'(i));
      tick();
    end
    clr_in();
    checks++;
    if (credit_avail_all !== 20'hEEEEE) begin
      failures++; $display("FAIL all_ports_drain got=%h exp=eeeee", credit_avail_all);
    end
    for (int p = 0; p < P; p++) put_flit(p, 1'b0, 1'b0, 4'b0001, 32'hD0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr_in();
    checks++;
    if (credit_avail_all !== 20'hFFFFF || vc_free_all !== 20'hFFFFF ||
        credit_err_all !== 5'h00 || flit_out_we_all !== 5'h00) begin
      failures++;
      $display("FAIL mid_packet_reset got=%h/%h/%b/%b exp=fffff/fffff/00000/00000",
               credit_avail_all, vc_free_all, credit_err_all, flit_out_we_all);
    end
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    test_reset();
    test_packet_stream();
    test_same_cycle();
    test_boundary_errors();
    test_malformed_and_single();
    test_all_ports();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
